// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: RISC-V funct3 access
// encodings, FSM state type and the alignment helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    // Halfword needs addr[0]==0, word needs addr[1:0]==0; bytes never misalign.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lo);
        case (size[1:0])
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: extends fetched little-endian bytes for loads
// and produces per-byte write enables for stores.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [31:0] rbytes_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic        ld_ok_o,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_bytes_o,
    output logic        st_ok_o
);

    always_comb begin
        ld_data_o  = '0;
        ld_ok_o    = 1'b0;
        st_be_o    = '0;
        st_ok_o    = 1'b0;
        st_bytes_o = wdata_i;
        case (size_i)
            F3_B: begin
                ld_data_o = {{24{rbytes_i[7]}}, rbytes_i[7:0]};
                ld_ok_o   = 1'b1;
                st_be_o   = 4'b0001;
                st_ok_o   = 1'b1;
            end
            F3_H: begin
                ld_data_o = {{16{rbytes_i[15]}}, rbytes_i[15:0]};
                ld_ok_o   = 1'b1;
                st_be_o   = 4'b0011;
                st_ok_o   = 1'b1;
            end
            F3_W: begin
                ld_data_o = rbytes_i;
                ld_ok_o   = 1'b1;
                st_be_o   = 4'b1111;
                st_ok_o   = 1'b1;
            end
            F3_BU: begin
                ld_data_o = {24'h0, rbytes_i[7:0]};
                ld_ok_o   = 1'b1;
            end
            F3_HU: begin
                ld_data_o = {16'h0, rbytes_i[15:0]};
                ld_ok_o   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory with fixed-latency request/response handshake.
// Optional alignment checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter  int unsigned XLEN   = 32,
    parameter  int unsigned DEPTH  = 128,
    parameter  int unsigned LAT    = 1,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [XLEN-1:0]    pend_rdata_q;
    logic               pend_err_q;
    logic               resp_valid_q;
    logic [XLEN-1:0]    resp_rdata_q;
    logic               resp_err_q;
    logic [7:0]         mem_q [DEPTH];

    logic [31:0]        fetch;
    logic [31:0]        ld_data;
    logic               ld_ok;
    logic [3:0]         st_be;
    logic [31:0]        st_bytes;
    logic               st_ok;
    logic               misaligned;
    logic               accept;
    logic               wr_en;
    logic [XLEN-1:0]    rsp_rdata_d;
    logic               rsp_err_d;

    assign req_ready  = (state_q == S_IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // Byte k of an access lives at addr+k, wrapping modulo DEPTH.
    always_comb begin
        fetch = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            fetch[8*k +: 8] = mem_q[req_addr + ADDR_W'(k)];
        end
    end

    dmem_lane_align u_align (
        .size_i     (req_size),
        .rbytes_i   (fetch),
        .wdata_i    (req_wdata),
        .ld_data_o  (ld_data),
        .ld_ok_o    (ld_ok),
        .st_be_o    (st_be),
        .st_bytes_o (st_bytes),
        .st_ok_o    (st_ok)
    );

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned = is_misaligned(req_size, req_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        rsp_err_d   = (req_we ? !st_ok : !ld_ok) || misaligned;
        rsp_rdata_d = (req_we || rsp_err_d) ? '0 : ld_data;
    end

    assign wr_en = accept && req_we && !rsp_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[ADDR_W'(i)] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (st_be[2'(k)]) begin
                    mem_q[req_addr + ADDR_W'(k)] <= st_bytes[8*k +: 8];
                end
            end
        end
    end

    // The response is resolved at accept and parked until the latency expires.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pend_rdata_q <= '0;
            pend_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        pend_rdata_q <= rsp_rdata_d;
                        pend_err_q   <= rsp_err_d;
                        if (LAT == 1) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= rsp_rdata_d;
                            resp_err_q   <= rsp_err_d;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_W'(LAT - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q      <= S_RESP;
                        cnt_q        <= '0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= pend_rdata_q;
                        resp_err_q   <= pend_err_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                end
                default: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: three instances at LAT=1, LAT=3 and LAT=4.
// Expectations follow DMEM_MISALIGN_CHECK_EN when the bench is built with it.
module tb_dmem_ctrl;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam logic [31:0] EXP_MIS_ERR = 32'h1;
    localparam logic [31:0] EXP_B126    = 32'h00;
    localparam logic [31:0] EXP_B127    = 32'h00;
    localparam logic [31:0] EXP_B0      = 32'h00;
    localparam logic [31:0] EXP_B1      = 32'h00;
    localparam logic [31:0] EXP_LW126   = 32'h0;
`else
    localparam logic [31:0] EXP_MIS_ERR = 32'h0;
    localparam logic [31:0] EXP_B126    = 32'hDD;
    localparam logic [31:0] EXP_B127    = 32'hCC;
    localparam logic [31:0] EXP_B0      = 32'hBB;
    localparam logic [31:0] EXP_B1      = 32'hAA;
    localparam logic [31:0] EXP_LW126   = 32'hAABBCCDD;
`endif

    logic        clk;
    logic        reset;
    logic        rst_c_x;
    logic [2:0]  vld;
    logic [2:0]  rdy;
    logic [2:0]  rv;
    logic [2:0]  rerr;
    logic [31:0] rdat [3];
    logic        req_we;
    logic [2:0]  req_size;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;

    int n_checks;
    int n_pass;

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          hits;

    dmem_ctrl #(.XLEN(32), .DEPTH(128), .LAT(1)) u_dut_a (
        .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv[0]), .resp_rdata(rdat[0]), .resp_err(rerr[0])
    );

    dmem_ctrl #(.XLEN(32), .DEPTH(128), .LAT(3)) u_dut_b (
        .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv[1]), .resp_rdata(rdat[1]), .resp_err(rerr[1])
    );

    dmem_ctrl #(.XLEN(32), .DEPTH(128), .LAT(4)) u_dut_c (
        .clk(clk), .reset(reset | rst_c_x), .req_valid(vld[2]), .req_ready(rdy[2]),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv[2]), .resp_rdata(rdat[2]), .resp_err(rerr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One request to instance d; returns the response and its latency (-1 if none).
    task automatic xact(input int d, input logic we, input logic [2:0] sz,
                        input logic [6:0] ad, input logic [31:0] wd,
                        output logic [31:0] o_rd, output logic o_er, output int o_lat);
        @(negedge clk);
        req_we    = we;
        req_size  = sz;
        req_addr  = ad;
        req_wdata = wd;
        vld[d]    = 1'b1;
        @(posedge clk);
        #1;
        vld   = '0;
        o_rd  = 'x;
        o_er  = 1'bx;
        o_lat = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (rv[d] === 1'b1) begin
                o_rd  = rdat[d];
                o_er  = rerr[d];
                o_lat = c;
                break;
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        rst_c_x   = 1'b0;
        vld       = '0;
        req_we    = 1'b0;
        req_size  = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(rv[0]), 32'h0);
        check("rst_rdata", rdat[0], 32'h0);
        check("rst_err", 32'(rerr[0]), 32'h0);
        check("rst_ready_a", 32'(rdy[0]), 32'h1);
        check("rst_ready_b", 32'(rdy[1]), 32'h1);

        // LAT=1 functional sequence
        xact(0, 1'b0, SZ_W, 7'd20, 32'h0, rd, er, lat);
        check("lw20_lat", lat, 32'd1);
        check("lw20_rdata", rd, 32'h0);
        check("lw20_err", 32'(er), 32'h0);
        @(negedge clk);
        check("strobe_one_cycle", 32'(rv[0]), 32'h0);
        check("idle_rdata_zero", rdat[0], 32'h0);

        xact(0, 1'b1, SZ_W, 7'd20, 32'h8000006D, rd, er, lat);
        check("sw20_rdata", rd, 32'h0);
        check("sw20_err", 32'(er), 32'h0);
        xact(0, 1'b0, SZ_B, 7'd23, 32'h0, rd, er, lat);
        check("lb23", rd, 32'hFFFFFF80);
        xact(0, 1'b0, SZ_BU, 7'd23, 32'h0, rd, er, lat);
        check("lbu23", rd, 32'h00000080);
        xact(0, 1'b0, SZ_H, 7'd20, 32'h0, rd, er, lat);
        check("lh20", rd, 32'h0000006D);
        xact(0, 1'b0, SZ_HU, 7'd22, 32'h0, rd, er, lat);
        check("lhu22", rd, 32'h00008000);
        xact(0, 1'b0, SZ_H, 7'd22, 32'h0, rd, er, lat);
        check("lh22", rd, 32'hFFFF8000);
        xact(0, 1'b0, SZ_W, 7'd20, 32'h0, rd, er, lat);
        check("lw20_after_sw", rd, 32'h8000006D);

        xact(0, 1'b1, SZ_H, 7'd40, 32'h1234ABCD, rd, er, lat);
        xact(0, 1'b1, SZ_B, 7'd43, 32'h123456EF, rd, er, lat);
        xact(0, 1'b0, SZ_W, 7'd40, 32'h0, rd, er, lat);
        check("sh_sb_merge", rd, 32'hEF00ABCD);

        // Word store straddling the top of memory
        xact(0, 1'b1, SZ_W, 7'd126, 32'hAABBCCDD, rd, er, lat);
        check("sw126_err", 32'(er), EXP_MIS_ERR);
        check("sw126_rdata", rd, 32'h0);
        xact(0, 1'b0, SZ_BU, 7'd126, 32'h0, rd, er, lat);
        check("byte126", rd, EXP_B126);
        xact(0, 1'b0, SZ_BU, 7'd127, 32'h0, rd, er, lat);
        check("byte127", rd, EXP_B127);
        xact(0, 1'b0, SZ_BU, 7'd0, 32'h0, rd, er, lat);
        check("byte0", rd, EXP_B0);
        xact(0, 1'b0, SZ_BU, 7'd1, 32'h0, rd, er, lat);
        check("byte1", rd, EXP_B1);
        xact(0, 1'b0, SZ_W, 7'd126, 32'h0, rd, er, lat);
        check("lw126", rd, EXP_LW126);

        // Illegal sizes
        xact(0, 1'b0, 3'b011, 7'd20, 32'h0, rd, er, lat);
        check("ld011_err", 32'(er), 32'h1);
        check("ld011_rdata", rd, 32'h0);
        xact(0, 1'b0, 3'b110, 7'd20, 32'h0, rd, er, lat);
        check("ld110_err", 32'(er), 32'h1);
        xact(0, 1'b1, 3'b100, 7'd20, 32'h00000011, rd, er, lat);
        check("st100_err", 32'(er), 32'h1);
        check("st100_rdata", rd, 32'h0);
        xact(0, 1'b1, 3'b011, 7'd20, 32'h22222222, rd, er, lat);
        check("st011_err", 32'(er), 32'h1);
        xact(0, 1'b0, SZ_W, 7'd20, 32'h0, rd, er, lat);
        check("no_write_on_err", rd, 32'h8000006D);

        // LAT=3 timing and busy-period request rejection
        @(negedge clk);
        req_we    = 1'b1;
        req_size  = SZ_W;
        req_addr  = 7'd8;
        req_wdata = 32'h11223344;
        vld[1]    = 1'b1;
        @(posedge clk);
        #1;
        req_wdata = 32'h55667788;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("lat3_valid_c%0d", c), 32'(rv[1]), (c == 3) ? 32'h1 : 32'h0);
            check($sformatf("lat3_ready_c%0d", c), 32'(rdy[1]), (c == 4) ? 32'h1 : 32'h0);
        end
        vld[1] = 1'b0;
        hits = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rv[1] === 1'b1) hits++;
        end
        check("lat3_no_queued_resp", hits, 32'd0);
        xact(1, 1'b0, SZ_W, 7'd8, 32'h0, rd, er, lat);
        check("lat3_lat", lat, 32'd3);
        check("lat3_busy_store_ignored", rd, 32'h11223344);

        // LAT=4 reset during a pending load
        xact(2, 1'b1, SZ_W, 7'd4, 32'hDEADBEEF, rd, er, lat);
        check("lat4_lat", lat, 32'd4);
        xact(2, 1'b0, SZ_W, 7'd4, 32'h0, rd, er, lat);
        check("lat4_lw4", rd, 32'hDEADBEEF);
        @(negedge clk);
        req_we   = 1'b0;
        req_size = SZ_W;
        req_addr = 7'd4;
        vld[2]   = 1'b1;
        @(posedge clk);
        #1;
        vld[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_c_x   = 1'b1;
        req_we    = 1'b1;
        req_wdata = 32'h12345678;
        vld[2]    = 1'b1;
        @(posedge clk);
        #1;
        vld[2] = 1'b0;
        @(negedge clk);
        rst_c_x = 1'b0;
        hits    = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rv[2] === 1'b1) hits++;
        end
        check("lat4_dropped_resp", hits, 32'd0);
        check("lat4_ready_after_rst", 32'(rdy[2]), 32'h1);
        xact(2, 1'b0, SZ_W, 7'd4, 32'h0, rd, er, lat);
        check("lat4_mem_cleared", rd, 32'h0);
        check("lat4_post_rst_lat", lat, 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
